// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Optional parity/stop checking is enabled by PS2_PARITY_CHK_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int DATA_BITS = 8;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

endpackage

// File: rtl/ps2_fifo.sv
// Byte FIFO for received scan codes.
// A pop frees the slot a same-cycle push needs when full.
module ps2_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  logic [7:0]       mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   cnt;
  logic pop_ok;
  logic push_ok;

  assign empty   = (cnt == '0);
  assign full    = cnt[FIFO_AW];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin sync, frame FSM, timeout, scan-code FIFO.
// Define PS2_PARITY_CHK_EN to reject frames with bad parity or stop bit.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ps2_rd,
  output logic [7:0] key,
  output logic       ps2_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] cs;
  logic [SYNC_STAGES-1:0] ds;
  logic       c_s, d_s, c_q, fe;
  rx_state_e  state_q, state_d;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic [TW-1:0] tcnt;
  logic tmo, stop_fe, accept, push;
  logic rd_q, pop_req, pop_ok;
  logic [7:0] dout;
  logic empty, full;

  assign c_s = cs[SYNC_STAGES-1];
  assign d_s = ds[SYNC_STAGES-1];
  assign fe  = c_q & ~c_s;
  assign tmo = (state_q != IDLE) & ~fe & (tcnt == TW'(TIMEOUT_CYC));
  assign stop_fe = fe & (state_q == STOP);

`ifdef PS2_PARITY_CHK_EN
  logic par;
  assign accept = (^{shreg, par}) & d_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par <= 1'b0;
    else if (fe && state_q == PARITY) par <= d_s;
  end
`else
  assign accept = 1'b1;
`endif

  assign push    = stop_fe & accept;
  assign pop_req = ps2_rd & ~rd_q;
  assign pop_ok  = pop_req & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs  <= '1;
      ds  <= '1;
      c_q <= 1'b1;
    end else begin
      cs  <= {cs[SYNC_STAGES-2:0], ps2_clk};
      ds  <= {ds[SYNC_STAGES-2:0], ps2_data};
      c_q <= c_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = IDLE;
    end else if (fe) begin
      unique case (state_q)
        IDLE:   if (!d_s) state_d = DATA;
        DATA:   if (bcnt == 3'(DATA_BITS - 1)) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt      <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      frame_err <= 1'b0;
      rd_q      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rd_q      <= ps2_rd;
      frame_err <= tmo | (stop_fe & ~accept);
      if (fe || tmo || state_q == IDLE) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
      if (tmo) begin
        bcnt  <= '0;
        shreg <= '0;
      end else if (fe && state_q == IDLE) begin
        bcnt <= '0;
      end else if (fe && state_q == DATA) begin
        shreg[bcnt] <= d_s;
        bcnt        <= bcnt + 3'd1;
      end
      // a pop from a full FIFO makes room, so it never overflows
      if (push && full && !pop_ok) overflow <= 1'b1;
      else if (pop_ok && full)     overflow <= 1'b0;
    end
  end

  ps2_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop_req),
    .din  (shreg),
    .dout (dout),
    .empty(empty),
    .full (full)
  );

  assign key       = empty ? 8'h00 : dout;
  assign ps2_ready = ~empty;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx with a shortened timeout.
module tb_ps2_kbd_rx;

  localparam int TMO = 1000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ps2_rd = 1'b0;
  logic [7:0] key;
  logic       ps2_ready;
  logic       overflow;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int f0;

  ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT_CYC(TMO), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_rd   (ps2_rd),
    .key      (key),
    .ps2_ready(ps2_ready),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) ferr_cnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (H) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    logic p;
    p = ~(^d) ^ bad_par;
    send_bits({1'b1, p, d, 1'b0}, 11);
    repeat (2 * H) @(posedge clk);
  endtask

  task automatic pop(input int n);
    @(posedge clk); #1 ps2_rd = 1'b1;
    repeat (n) @(posedge clk);
    #1 ps2_rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key", key, 8'h00);
    check("rst_rdy", ps2_ready, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    send_byte(8'h1C, 1'b0);
    @(negedge clk);
    check("t1_rdy", ps2_ready, 1'b1);
    check("t1_key", key, 8'h1C);
    pop(4);
    check("t1_rdy_after", ps2_ready, 1'b0);
    check("t1_key_after", key, 8'h00);
    check("t1_ferr", ferr_cnt, 0);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0);
    @(negedge clk);
    check("t2_k0", key, 8'hF0);
    pop(1);
    check("t2_k1", key, 8'h1C);
    pop(2);
    check("t2_k2", key, 8'hE0);
    check("t2_rdy2", ps2_ready, 1'b1);
    pop(1);
    check("t2_rdy3", ps2_ready, 1'b0);

    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    check("t3_ovf", overflow, 1'b1);
    check("t3_key", key, 8'h01);
    pop(1);
    check("t3_ovf_clr", overflow, 1'b0);
    check("t3_key2", key, 8'h02);
    for (int i = 0; i < 7; i++) pop(1);
    check("t3_drained", ps2_ready, 1'b0);

    f0 = ferr_cnt;
    send_byte(8'h1C, 1'b1);
    @(negedge clk);
`ifdef PS2_PARITY_CHK_EN
    check("t4_rdy", ps2_ready, 1'b0);
    check("t4_ferr", ferr_cnt - f0, 1);
`else
    check("t4_key", key, 8'h1C);
    check("t4_ferr", ferr_cnt - f0, 0);
    pop(1);
`endif

    f0 = ferr_cnt;
    send_bits({1'b1, 1'b0, 8'h0F, 1'b0}, 5);
    repeat (TMO + 5) @(posedge clk);
    @(negedge clk);
    check("t5_ferr", ferr_cnt - f0, 1);
    check("t5_rdy", ps2_ready, 1'b0);
    send_byte(8'h29, 1'b0);
    @(negedge clk);
    check("t5_key", key, 8'h29);
    check("t5_rdy2", ps2_ready, 1'b1);
    pop(1);

    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 5);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("t6_key", key, 8'h00);
    check("t6_rdy", ps2_ready, 1'b0);
    check("t6_ovf", overflow, 1'b0);
    check("t6_ferr", frame_err, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    send_byte(8'h33, 1'b0);
    @(negedge clk);
    check("t6_key2", key, 8'h33);
    pop(1);
    check("t6_empty", ps2_ready, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver that sits upstream of the memory/IO bus decoder.
- Deserialises 11-bit device-to-host frames from the keyboard pins and queues scan-code bytes in a small FIFO.
- Presents the FIFO head as key[7:0], with ps2_ready = FIFO non-empty, for CPU reads in the 0x2xxxxxxx window.
- Pops one byte per CPU read strobe (ps2_rd).

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries (8).
- TIMEOUT_CYC, 100000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.
- SYNC_STAGES, 2, flip-flop stages on the ps2_clk and ps2_data synchronisers (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ps2_clk  input  1  raw keyboard clock pin (asynchronous)
- ps2_data  input  1  raw keyboard data pin (asynchronous)
- ps2_rd  input  1  bus read strobe (level; may be held several cycles)
- key  output  8  FIFO head byte; 8'h00 when empty
- ps2_ready  output  1  FIFO non-empty
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full
- frame_err  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset is asynchronous and active-high. All state clears: synchronisers to 1, bit count 0, shift register 0, FIFO pointers 0, key=0, ps2_ready=0, overflow=0, frame_err=0, timeout counter 0.
- Synchronise both pins through SYNC_STAGES flops. A falling edge (fe) is synced-clk previous=1 and current=0.
- Receive FSM:
  - IDLE: on fe with data=0 (start bit), go to DATA with bcnt=0. On fe with data=1, stay in IDLE (glitch ignored).
  - DATA: each fe shifts data into bit bcnt (LSB first) and increments bcnt. After 8 bits, go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, evaluate the frame (see Optional Feature), then return to IDLE.
- Timeout: a counter resets on every fe and increments while the FSM is not IDLE. At TIMEOUT_CYC it forces IDLE, discards the partial byte and pulses frame_err.
- Push: on an accepted frame, the byte is written to the FIFO the cycle after the stop-bit fe.
  - If the FIFO is full, the byte is discarded and overflow sets. overflow clears only on reset or on a pop from a full FIFO.
- Pop: ps2_rd is rising-edge detected (ps2_rd & ~ps2_rd_q), so one pop per bus access regardless of strobe length. A pop on an empty FIFO is ignored.
- Simultaneous push and pop:
  - Non-empty FIFO: both occur; count is unchanged.
  - Empty FIFO: push only.
  - Full FIFO: pop then push, both succeed; no overflow.
- key and ps2_ready are combinational from the FIFO head and count. key=8'h00 when empty.
- Latency: key and ps2_ready update 1 cycle after the stop-bit fe is detected, which is SYNC_STAGES+1 cycles after the pin edge. After a pop edge, the next head is visible 1 cycle later.

Optional Feature:
- Macro: PS2_PARITY_CHK_EN
- Defined: a frame is accepted only if the parity is odd (^{data,parity}==1) and the stop bit is 1. Otherwise the frame is dropped and frame_err pulses for 1 cycle.
- Undefined: parity and stop bits are ignored, every completed frame is pushed, and frame_err pulses only on timeout.

Decomposition:
- Package ps2_pkg:
  - FSM state encoding: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - Frame constants: DATA_BITS=8.
  - Scan-code constants: BREAK_PREFIX=8'hF0, EXT_PREFIX=8'hE0.
- Sub-module ps2_fifo:
  - Synchronous, parameterised by FIFO_AW, width 8.
  - Ports: push, pop, din, dout, empty, full.
  - Pop-then-push ordering when full.
- Top module holds the synchronisers, FSM, timeout and pop-edge logic.

Test Plan:
- Drive a valid frame for 8'h1C (start 0, LSB-first 0011 1000, parity 0, stop 1) at 12.5 kHz -> ps2_ready=1, key=8'h1C. Hold ps2_rd high 4 cycles -> exactly one pop; ps2_ready=0, key=8'h00.
- Send 3 frames 8'hF0, 8'h1C, 8'hE0 without reading -> successive ps2_rd pulses return F0, 1C, E0 in order; ps2_ready falls after the third pop.
- Send 9 frames to the empty depth-8 FIFO -> 9th byte dropped, overflow=1. The next ps2_rd returns byte 1 and clears overflow.
- With PS2_PARITY_CHK_EN, send 8'h1C with parity 1 -> no push, frame_err pulses once, ps2_ready stays 0. Without the macro -> key=8'h1C.
- Send start bit plus 4 data bits, then idle TIMEOUT_CYC+5 cycles -> frame_err pulses and FSM is back in IDLE. A following valid 8'h29 frame is received intact.
- Assert rst mid-frame (after 5 bits) with 2 bytes queued -> all outputs 0 immediately. Frames after rst deasserts are received correctly.
